// File: rtl/reg_dump.sv
// reg_dump: snapshots the five architectural registers on request and streams
// them out as a framed, checksummed byte sequence over a valid/ready link.
module reg_dump (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] pc_i,
  input  logic [7:0] cacheptr_i,
  input  logic [7:0] stackptr_i,
  input  logic [7:0] headptr_i,
  input  logic [7:0] register_i,
  output logic       busy_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  input  logic       out_ready_i,
  output logic       done_o
);

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    REG,
    CSUM
  } state_t;

  state_t     state, next_state;
  logic [2:0] idx, next_idx;
  logic       load_snap;
  logic       done_next;
  logic       handshake;
  logic [7:0] snap_pc, snap_cacheptr, snap_stackptr, snap_headptr, snap_register;
  logic [7:0] csum;
  logic [7:0] reg_byte;

  assign handshake = out_valid_o & out_ready_i;
  assign csum = snap_pc + snap_cacheptr + snap_stackptr + snap_headptr + snap_register;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 3'd0;
      done_o        <= 1'b0;
      snap_pc       <= 8'h00;
      snap_cacheptr <= 8'h00;
      snap_stackptr <= 8'h00;
      snap_headptr  <= 8'h00;
      snap_register <= 8'h00;
    end else begin
      state  <= next_state;
      idx    <= next_idx;
      done_o <= done_next;
      if (load_snap) begin
        snap_pc       <= pc_i;
        snap_cacheptr <= cacheptr_i;
        snap_stackptr <= stackptr_i;
        snap_headptr  <= headptr_i;
        snap_register <= register_i;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    load_snap  = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          next_state = HDR;
          load_snap  = 1'b1;
        end
      end
      HDR: begin
        if (handshake) begin
          next_state = REG;
          next_idx   = 3'd0;
        end
      end
      REG: begin
        if (handshake) begin
          if (idx == 3'd4) next_state = CSUM;
          else             next_idx   = idx + 3'd1;
        end
      end
      CSUM: begin
        if (handshake) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output byte is selected purely from registered state, so out_ready_i never reaches it.
  always_comb begin
    reg_byte = 8'h00;
    case (idx)
      3'd0:    reg_byte = snap_pc;
      3'd1:    reg_byte = snap_cacheptr;
      3'd2:    reg_byte = snap_stackptr;
      3'd3:    reg_byte = snap_headptr;
      3'd4:    reg_byte = snap_register;
      default: reg_byte = 8'h00;
    endcase
  end

  always_comb begin
    out_data_o = 8'h00;
    case (state)
      HDR:     out_data_o = HEADER;
      REG:     out_data_o = reg_byte;
      CSUM:    out_data_o = csum;
      default: out_data_o = 8'h00;
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign out_valid_o = (state != IDLE);
  assign out_last_o  = (state == CSUM);

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed self-checking bench for reg_dump frames, backpressure,
// snapshot isolation, checksum wrap, back-to-back starts and mid-frame reset.
module tb_reg_dump;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] pc_i = 8'h00;
  logic [7:0] cacheptr_i = 8'h00;
  logic [7:0] stackptr_i = 8'h00;
  logic [7:0] headptr_i = 8'h00;
  logic [7:0] register_i = 8'h00;
  logic       out_ready_i = 1'b0;
  logic       busy_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_last_o;
  logic       done_o;

  int checks = 0;
  int failures = 0;

  reg_dump dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .cacheptr_i  (cacheptr_i),
    .stackptr_i  (stackptr_i),
    .headptr_i   (headptr_i),
    .register_i  (register_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] pc, input logic [7:0] cp, input logic [7:0] sp,
                               input logic [7:0] hp, input logic [7:0] rg);
    pc_i       = pc;
    cacheptr_i = cp;
    stackptr_i = sp;
    headptr_i  = hp;
    register_i = rg;
  endtask

  // Called at a negedge; leaves the bench at the negedge where HEADER is first visible.
  task automatic pulseStart(input string tag);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput({tag, "_valid"}, 8'(out_valid_o), 8'd1);
    checkOutput({tag, "_hdr"}, out_data_o, 8'hA5);
    checkOutput({tag, "_busy"}, 8'(busy_o), 8'd1);
  endtask

  // Called at a negedge; returns at the negedge of the done_o cycle.
  task automatic collectFrame(input string tag, input logic [7:0] pc, input logic [7:0] cp,
                              input logic [7:0] sp, input logic [7:0] hp, input logic [7:0] rg,
                              input logic [7:0] cs, input int mode);
    logic [7:0] exp [7];
    int         k = 0;
    int         stall = 0;
    logic       prev_stalled = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp[0] = 8'hA5; exp[1] = pc; exp[2] = cp; exp[3] = sp;
    exp[4] = hp;    exp[5] = rg; exp[6] = cs;
    for (int cyc = 0; cyc < 400 && k < 7; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (mode == 0) out_ready_i = 1'b1;
      else if (k == 1 && stall < 10) begin
        out_ready_i = 1'b0;
        stall++;
      end else out_ready_i = 1'($urandom_range(0, 1));
      if (prev_stalled) begin
        checkOutput({tag, "_stall_valid"}, 8'(out_valid_o), 8'd1);
        checkOutput({tag, "_stall_data"}, out_data_o, prev_data);
      end
      prev_stalled = 1'b0;
      if (out_valid_o) begin
        if (out_ready_i) begin
          checkOutput($sformatf("%s_byte%0d", tag, k), out_data_o, exp[k]);
          checkOutput($sformatf("%s_last%0d", tag, k), 8'(out_last_o), 8'((k == 6) ? 1 : 0));
          checkOutput($sformatf("%s_done_low%0d", tag, k), 8'(done_o), 8'd0);
          k++;
        end else begin
          prev_stalled = 1'b1;
          prev_data    = out_data_o;
        end
      end
    end
    checkOutput({tag, "_frame_complete"}, 8'(k), 8'd7);
    @(negedge clk);
    out_ready_i = 1'b1;
    checkOutput({tag, "_done"}, 8'(done_o), 8'd1);
    checkOutput({tag, "_done_busy"}, 8'(busy_o), 8'd0);
    checkOutput({tag, "_done_valid"}, 8'(out_valid_o), 8'd0);
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_busy", 8'(busy_o), 8'd0);
    checkOutput("rst_valid", 8'(out_valid_o), 8'd0);
    checkOutput("rst_data", out_data_o, 8'h00);
    checkOutput("rst_last", 8'(out_last_o), 8'd0);
    checkOutput("rst_done", 8'(done_o), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ready ahead of valid does nothing while idle
    out_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_valid", 8'(out_valid_o), 8'd0);
    end

    $display("[TB] basic dump");
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
    pulseStart("basic");
    collectFrame("basic", 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hAE, 0);

    $display("[TB] snapshot isolation");
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    collectFrame("snap", 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hAE, 0);

    $display("[TB] checksum wrap");
    @(negedge clk);
    pulseStart("wrap");
    collectFrame("wrap", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 0);

    $display("[TB] backpressure");
    @(negedge clk);
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
    pulseStart("bp");
    collectFrame("bp", 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hAE, 1);

    $display("[TB] back-to-back with start held");
    @(negedge clk);
    applyStimulus(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    start_i = 1'b1;
    @(negedge clk);
    collectFrame("b2b1", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F, 0);
    @(negedge clk);
    checkOutput("b2b_restart_valid", 8'(out_valid_o), 8'd1);
    checkOutput("b2b_restart_hdr", out_data_o, 8'hA5);
    collectFrame("b2b2", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F, 0);
    start_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("b2b_no_third", 8'(out_valid_o), 8'd0);
    end

    $display("[TB] reset mid-frame");
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
    pulseStart("mid");
    repeat (3) @(negedge clk);
    checkOutput("mid_pre_reset", out_data_o, 8'h56);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 8'(out_valid_o), 8'd0);
    checkOutput("mid_rst_data", out_data_o, 8'h00);
    checkOutput("mid_rst_busy", 8'(busy_o), 8'd0);
    checkOutput("mid_rst_last", 8'(out_last_o), 8'd0);
    checkOutput("mid_rst_done", 8'(done_o), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 8'(out_valid_o), 8'd0);
      checkOutput("post_rst_done", 8'(done_o), 8'd0);
    end
    pulseStart("post");
    collectFrame("post", 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hAE, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out engine for the CPU register file: on request it snapshots the five architectural registers (PC, cacheptr, stackptr, headptr, register) in one cycle. It then streams them out as a framed byte sequence over a valid/ready interface toward the debug/host link. It is a passive reader: it never writes the register file and never stalls the core.

## Interface
- HEADER, 8'hA5, first byte of every frame
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_i  input  1  dump request; sampled only while busy_o=0
- pc_i  input  8  register file PC output
- cacheptr_i  input  8  register file cacheptr output
- stackptr_i  input  8  register file stackptr output
- headptr_i  input  8  register file headptr output
- register_i  input  8  register file general register output
- busy_o  output  1  frame in progress (snapshot held)
- out_valid_o  output  1  out_data_o holds a byte to transfer
- out_data_o  output  8  frame byte
- out_last_o  output  1  current byte is the final (checksum) byte
- out_ready_i  input  1  downstream accepts byte when high with out_valid_o
- done_o  output  1  one-cycle pulse after final byte transfers

## Operation
- Frame, 7 bytes, in order: HEADER, PC, cacheptr, stackptr, headptr, register, CSUM.
- CSUM = (PC + cacheptr + stackptr + headptr + register) mod 256. HEADER is excluded. Computed from the snapshot with 8-bit wrap and no carry out.
- Snapshot: on the rising edge where state=IDLE and start_i=1, latch all five inputs into internal snapshot registers. Later changes to the inputs do not affect the frame.
- FSM states and transitions:
  - IDLE: out_valid_o=0. Goes to HDR on start_i.
  - HDR: drive HEADER. Goes to REG on handshake, with idx=0.
  - REG: drive snapshot[idx]. idx is a 3-bit counter, 0..4. A handshake with idx<4 increments idx; a handshake with idx=4 goes to CSUM.
  - CSUM: drive checksum with out_last_o=1. Goes to IDLE on handshake and pulses done_o.
- Handshake = out_valid_o & out_ready_i at a rising edge. Without a handshake, state, out_data_o and out_last_o hold.
- busy_o=1 in HDR, REG and CSUM.
- start_i during busy_o=1 is ignored. It is not queued.
- out_last_o=1 only in CSUM.
- The checksum may be accumulated incrementally or computed combinationally from the snapshot. out_data_o must be registered or driven from stable registered state; no combinational path from out_ready_i to out_data_o.

## Timing
- Reset (asynchronous, immediate): state=IDLE, idx=0, snapshot=0, busy_o=0, out_valid_o=0, out_data_o=8'h00, out_last_o=0, done_o=0.
- Reset asserted mid-frame abandons the frame. No partial bytes or done_o follow after release.
- Latency: start_i sampled high at edge N → out_valid_o=1 with HEADER from edge N up to and including the edge where the HEADER handshake occurs.
- With out_ready_i held high, one byte transfers per cycle. A 7-byte frame occupies 7 cycles.
- done_o is high for the single cycle after the CSUM handshake edge. busy_o=0 in that same cycle.
- A start_i high in the done_o cycle is accepted. This makes back-to-back frames possible with exactly one out_valid_o=0 cycle between them.
- out_valid_o never drops without a handshake, except on reset.
- out_ready_i may be asserted before out_valid_o. It has no effect in IDLE.

## Test plan
- Basic dump: PC=12, cacheptr=34, stackptr=56, headptr=78, register=9A (hex), start_i pulse, out_ready_i=1 → bytes A5 12 34 56 78 9A AE on 7 consecutive cycles. out_last_o only on AE. done_o one cycle later.
- Snapshot isolation: same values. Change all inputs to FF one cycle after start_i → frame is still A5 12 34 56 78 9A AE.
- Backpressure: toggle out_ready_i randomly, including a 10-cycle low during the PC byte → out_data_o/out_valid_o stay stable while stalled. Same 7 bytes, no loss or duplication.
- Checksum wrap: all registers FF → frame A5 FF FF FF FF FF FB.
- Start while busy plus back-to-back: assert start_i throughout two frames → second start is taken in the done_o cycle. Exactly 2 frames, with one idle cycle between them.
- Reset mid-frame: assert rst_n=0 after the 3rd byte → all outputs 0 immediately. After release, no output until a new start_i, and the next frame is complete and correct.
